// File: rtl/spi_txn_arbiter.sv
// Arbitrates two byte requesters onto one spi_master: grant, load, send, drain, ack.
// Optional SEND-timeout abort is compiled in with `define SPI_TIMEOUT_EN.
module spi_txn_arbiter #(
  parameter int unsigned PRIO_FIXED     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 8192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       dc0,
  input  logic       lock0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  input  logic       dc1,
  input  logic       lock1,
  output logic       ack1,
  output logic [1:0] grant,
  output logic       spi_send,
  output logic [7:0] spi_data_out,
  output logic       dc_in,
  input  logic       spi_send_done,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StDrain} state_e;

  state_e     state_q;
  logic [1:0] grant_q;
  logic       last_owner_q;
  logic       locked_q;
  logic       ack0_q, ack1_q;
  logic       send_q;
  logic [7:0] data_q;
  logic       dc_q;

  // Owner index is grant_q[1]; meaningful only while a grant is held.
  logic       own_req, own_lock, own_dc, pick1;
  logic [7:0] own_data;
  logic       tmo_hit;

  always_comb begin
    own_req  = grant_q[1] ? req1 : req0;
    own_lock = grant_q[1] ? lock1 : lock0;
    own_dc   = grant_q[1] ? dc1 : dc0;
    own_data = grant_q[1] ? data1 : data0;
    if (req0 && req1) begin
      pick1 = (PRIO_FIXED != 0) ? 1'b0 : ~last_owner_q;
    end else begin
      pick1 = req1;
    end
  end

`ifdef SPI_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CntW-1:0] tmo_cnt_q;
  logic            timeout_q;

  assign tmo_hit = (tmo_cnt_q >= CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == StLoad) begin
        tmo_cnt_q <= '0;
      end else if (state_q == StSend && tmo_cnt_q != '1) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
      if (state_q == StSend && !spi_send_done && tmo_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 2'b00;
      last_owner_q <= 1'b1;
      locked_q     <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      send_q       <= 1'b0;
      data_q       <= 8'h00;
      dc_q         <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (locked_q) begin
            // A locked owner that drops req gives up the lock; arbitrate next cycle.
            if (own_req) begin
              state_q <= StLoad;
            end else begin
              locked_q <= 1'b0;
              grant_q  <= 2'b00;
            end
          end else if (req0 || req1) begin
            grant_q <= pick1 ? 2'b10 : 2'b01;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          data_q  <= own_data;
          dc_q    <= own_dc;
          send_q  <= 1'b1;
          state_q <= StSend;
        end
        StSend: begin
          if (spi_send_done) begin
            send_q  <= 1'b0;
            ack0_q  <= ~grant_q[1];
            ack1_q  <= grant_q[1];
            state_q <= StDrain;
          end else if (tmo_hit) begin
            send_q  <= 1'b0;
            state_q <= StDrain;
          end
        end
        StDrain: begin
          // Hold here until the master's done level falls so it is not reused.
          if (!spi_send_done) begin
            last_owner_q <= grant_q[1];
            locked_q     <= own_lock;
            if (!own_lock) begin
              grant_q <= 2'b00;
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign grant        = grant_q;
  assign spi_send     = send_q;
  assign spi_data_out = data_q;
  assign dc_in        = dc_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: two instances (round-robin and fixed priority)
// driven from shared requester stimulus plus a simple spi_master done-level model.
module tb_spi_txn_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_rr, rst_fx;
  logic       req0, req1, dc0, dc1, lock0, lock1;
  logic [7:0] data0, data1;
  logic       done = 1'b0;

  logic       rr_ack0, rr_ack1, rr_send, rr_dc, rr_busy, rr_tmo;
  logic [1:0] rr_grant;
  logic [7:0] rr_data;
  logic       fx_ack0, fx_ack1, fx_send, fx_dc, fx_busy, fx_tmo;
  logic [1:0] fx_grant;
  logic [7:0] fx_data;

  spi_txn_arbiter #(.PRIO_FIXED(0), .TIMEOUT_CYCLES(64)) u_rr (
    .clk(clk), .rst(rst_rr),
    .req0(req0), .data0(data0), .dc0(dc0), .lock0(lock0), .ack0(rr_ack0),
    .req1(req1), .data1(data1), .dc1(dc1), .lock1(lock1), .ack1(rr_ack1),
    .grant(rr_grant), .spi_send(rr_send), .spi_data_out(rr_data), .dc_in(rr_dc),
    .spi_send_done(done), .busy(rr_busy), .timeout(rr_tmo)
  );

  spi_txn_arbiter #(.PRIO_FIXED(1), .TIMEOUT_CYCLES(64)) u_fx (
    .clk(clk), .rst(rst_fx),
    .req0(req0), .data0(data0), .dc0(dc0), .lock0(lock0), .ack0(fx_ack0),
    .req1(req1), .data1(data1), .dc1(dc1), .lock1(lock1), .ack1(fx_ack1),
    .grant(fx_grant), .spi_send(fx_send), .spi_data_out(fx_data), .dc_in(fx_dc),
    .spi_send_done(done), .busy(fx_busy), .timeout(fx_tmo)
  );

  logic       sel_fx = 1'b0;
  logic       cur_ack0, cur_ack1, cur_send, cur_dc, cur_busy, cur_tmo;
  logic [1:0] cur_grant;
  logic [7:0] cur_data;
  assign cur_ack0  = sel_fx ? fx_ack0  : rr_ack0;
  assign cur_ack1  = sel_fx ? fx_ack1  : rr_ack1;
  assign cur_send  = sel_fx ? fx_send  : rr_send;
  assign cur_dc    = sel_fx ? fx_dc    : rr_dc;
  assign cur_busy  = sel_fx ? fx_busy  : rr_busy;
  assign cur_tmo   = sel_fx ? fx_tmo   : rr_tmo;
  assign cur_grant = sel_fx ? fx_grant : rr_grant;
  assign cur_data  = sel_fx ? fx_data  : rr_data;

  // Master model: done rises done_delay cycles after spi_send, stays high done_hold cycles.
  logic mdl_en = 1'b0;
  logic mdl_active = 1'b0;
  int   mdl_cnt = 0;
  int   done_delay = 3;
  int   done_hold = 5;
  always @(negedge clk) begin
    if (!mdl_en) begin
      done       <= 1'b0;
      mdl_active <= 1'b0;
    end else if (!mdl_active) begin
      if (cur_send) begin
        mdl_active <= 1'b1;
        mdl_cnt    <= 0;
      end
    end else begin
      mdl_cnt <= mdl_cnt + 1;
      if (mdl_cnt + 1 == done_delay) done <= 1'b1;
      if (mdl_cnt + 1 == done_delay + done_hold) begin
        done       <= 1'b0;
        mdl_active <= 1'b0;
      end
    end
  end

  int n_checks = 0;
  int n_pass = 0;
  logic [9:0] acks_q[$];  // {owner, dc_in, spi_data_out} captured at each ack

  task automatic step();
    @(posedge clk);
    #1;
    if (cur_ack0) acks_q.push_back({1'b0, cur_dc, cur_data});
    if (cur_ack1) acks_q.push_back({1'b1, cur_dc, cur_data});
  endtask

  task automatic do_reset(input logic use_fx);
    sel_fx = use_fx;
    mdl_en = 1'b0;
    rst_rr = 1'b1; rst_fx = 1'b1;
    req0 = 0; req1 = 0; dc0 = 0; dc1 = 0; lock0 = 0; lock1 = 0; data0 = 0; data1 = 0;
    step(); step();
    rst_rr = use_fx; rst_fx = ~use_fx;
    acks_q.delete();
    mdl_en = 1'b1;
  endtask

  task automatic wait_idle(input int bound);
    int c = 0;
    while (cur_busy && c < bound) begin step(); c++; end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    rst_rr = 1'b1; req0 = 1'b1; data0 = 8'hFF; dc0 = 1'b1;
    step(); step();
    n_checks++; if (cur_grant !== 2'b00) $display("FAIL rst_grant got %b want 00", cur_grant); else n_pass++;
    n_checks++; if (cur_send !== 1'b0) $display("FAIL rst_send got %b want 0", cur_send); else n_pass++;
    n_checks++; if (cur_data !== 8'h00) $display("FAIL rst_data got %h want 00", cur_data); else n_pass++;
    n_checks++; if (cur_dc !== 1'b0) $display("FAIL rst_dc got %b want 0", cur_dc); else n_pass++;
    n_checks++; if ({cur_ack0, cur_ack1} !== 2'b00) $display("FAIL rst_ack got %b want 00", {cur_ack0, cur_ack1}); else n_pass++;
    n_checks++; if (cur_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", cur_busy); else n_pass++;
    n_checks++; if (cur_tmo !== 1'b0) $display("FAIL rst_timeout got %b want 0", cur_tmo); else n_pass++;
    req0 = 1'b0; rst_rr = 1'b0;
  endtask

  task automatic test_single_byte();
    int c = 0;
    do_reset(1'b0);
    done_delay = 20; done_hold = 200;
    req0 = 1'b1; data0 = 8'hAE; dc0 = 1'b0;
    step();
    n_checks++; if (cur_grant !== 2'b01) $display("FAIL single_grant_load got %b want 01", cur_grant); else n_pass++;
    n_checks++; if ({cur_busy, cur_send} !== 2'b10) $display("FAIL single_load_busy_send got %b want 10", {cur_busy, cur_send}); else n_pass++;
    step();
    n_checks++; if (cur_send !== 1'b1) $display("FAIL single_send got %b want 1", cur_send); else n_pass++;
    n_checks++; if ({cur_dc, cur_data} !== 9'h0AE) $display("FAIL single_data got %h want 0ae", {cur_dc, cur_data}); else n_pass++;
    while (!cur_ack0 && c < 100) begin step(); c++; end
    n_checks++; if (cur_ack0 !== 1'b1) $display("FAIL single_ack0_seen got %b want 1", cur_ack0); else n_pass++;
    req0 = 1'b0;
    step();
    n_checks++; if (cur_ack0 !== 1'b0) $display("FAIL single_ack0_width got %b want 0", cur_ack0); else n_pass++;
    n_checks++; if (cur_grant !== 2'b01) $display("FAIL single_grant_drain got %b want 01", cur_grant); else n_pass++;
    n_checks++; if (cur_busy !== 1'b1) $display("FAIL single_busy_drain got %b want 1", cur_busy); else n_pass++;
    wait_idle(400);
    n_checks++; if ({cur_busy, done} !== 2'b00) $display("FAIL single_idle_after_done got %b want 00", {cur_busy, done}); else n_pass++;
    n_checks++; if (cur_grant !== 2'b00) $display("FAIL single_grant_end got %b want 00", cur_grant); else n_pass++;
    repeat (5) step();
    n_checks++; if (acks_q.size() != 1) $display("FAIL single_ack_count got %0d want 1", acks_q.size()); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [9:0] exp_q[4];
    int seen = 0;
    int cyc = 0;
    exp_q = '{10'h010, 10'h380, 10'h011, 10'h381};
    do_reset(1'b0);
    done_delay = 3; done_hold = 5;
    req0 = 1; req1 = 1; data0 = 8'h10; dc0 = 0; data1 = 8'h80; dc1 = 1;
    while (acks_q.size() < 4 && cyc < 500) begin
      step(); cyc++;
      while (seen < acks_q.size()) begin
        if (acks_q[seen][9]) data1++; else data0++;
        seen++;
      end
    end
    req0 = 0; req1 = 0;
    wait_idle(100);
    repeat (5) step();
    n_checks++; if (acks_q.size() != 4) $display("FAIL rr_ack_count got %0d want 4", acks_q.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i < acks_q.size()) begin
        n_checks++;
        if (acks_q[i] !== exp_q[i]) $display("FAIL rr_ack%0d got %h want %h", i, acks_q[i], exp_q[i]);
        else n_pass++;
      end
    end
    n_checks++; if (cur_grant !== 2'b00) $display("FAIL rr_grant_end got %b want 00", cur_grant); else n_pass++;
  endtask

  task automatic test_lock_burst();
    logic [9:0] exp_q[4];
    int seen = 0;
    int k0 = 0;
    int cyc = 0;
    exp_q = '{10'h021, 10'h000, 10'h07F, 10'h355};
    do_reset(1'b0);
    done_delay = 3; done_hold = 5;
    req0 = 1; data0 = 8'h21; dc0 = 0; lock0 = 1;
    req1 = 1; data1 = 8'h55; dc1 = 1;
    while (acks_q.size() < 4 && cyc < 800) begin
      step(); cyc++;
      while (seen < acks_q.size()) begin
        if (acks_q[seen][9]) begin
          req1 = 0;
        end else begin
          k0++;
          data0 = (k0 == 1) ? 8'h00 : 8'h7F;
          if (k0 == 3) req0 = 0;
        end
        seen++;
      end
      // Last byte of the burst releases the lock before its drain completes.
      if (k0 == 2 && cur_send) lock0 = 0;
    end
    req0 = 0; req1 = 0; lock0 = 0;
    wait_idle(100);
    n_checks++; if (acks_q.size() != 4) $display("FAIL lock_ack_count got %0d want 4", acks_q.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i < acks_q.size()) begin
        n_checks++;
        if (acks_q[i] !== exp_q[i]) $display("FAIL lock_ack%0d got %h want %h", i, acks_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_fixed_prio();
    logic [9:0] exp_q[4];
    int seen = 0;
    int k0 = 0;
    int cyc = 0;
    exp_q = '{10'h030, 10'h031, 10'h032, 10'h390};
    do_reset(1'b1);
    done_delay = 3; done_hold = 5;
    req0 = 1; data0 = 8'h30; dc0 = 0;
    req1 = 1; data1 = 8'h90; dc1 = 1;
    while (acks_q.size() < 4 && cyc < 800) begin
      step(); cyc++;
      while (seen < acks_q.size()) begin
        if (acks_q[seen][9]) begin
          req1 = 0;
        end else begin
          k0++;
          data0++;
          if (k0 == 3) req0 = 0;
        end
        seen++;
      end
    end
    req0 = 0; req1 = 0;
    wait_idle(100);
    n_checks++; if (acks_q.size() != 4) $display("FAIL fx_ack_count got %0d want 4", acks_q.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i < acks_q.size()) begin
        n_checks++;
        if (acks_q[i] !== exp_q[i]) $display("FAIL fx_ack%0d got %h want %h", i, acks_q[i], exp_q[i]);
        else n_pass++;
      end
    end
    sel_fx = 1'b0; rst_fx = 1'b1;
  endtask

  task automatic test_stale_done();
    int cyc = 0;
    int seen = 0;
    int ack1_cyc = -1;
    int rise_cyc = -1;
    int viol = 0;
    logic prev_send = 1'b0;
    do_reset(1'b0);
    done_delay = 3; done_hold = 300;
    req0 = 1; data0 = 8'h44; dc0 = 0;
    while (acks_q.size() < 2 && cyc < 1000) begin
      step(); cyc++;
      if (cur_send && done) viol++;
      if (cur_send && !prev_send && ack1_cyc >= 0 && rise_cyc < 0) rise_cyc = cyc;
      prev_send = cur_send;
      while (seen < acks_q.size()) begin
        if (seen == 0) begin ack1_cyc = cyc; data0 = 8'h45; end
        else req0 = 0;
        seen++;
      end
    end
    req0 = 0;
    wait_idle(400);
    repeat (5) step();
    n_checks++; if (acks_q.size() != 2) $display("FAIL stale_ack_count got %0d want 2", acks_q.size()); else n_pass++;
    n_checks++; if (viol != 0) $display("FAIL stale_send_with_done got %0d want 0", viol); else n_pass++;
    n_checks++;
    if (rise_cyc - ack1_cyc < 295) $display("FAIL stale_gap got %0d want >=295", rise_cyc - ack1_cyc);
    else n_pass++;
    if (acks_q.size() == 2) begin
      n_checks++;
      if (acks_q[1] !== 10'h045) $display("FAIL stale_second_byte got %h want 045", acks_q[1]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    do_reset(1'b0);
    done_delay = 20; done_hold = 5;
    req0 = 1; data0 = 8'h5A; dc0 = 1;
    while (!cur_send && c < 10) begin step(); c++; end
    step(); step();
    rst_rr = 1'b1; req0 = 0;
    step();
    rst_rr = 1'b0;
    n_checks++; if ({cur_busy, cur_send, cur_grant} !== 4'b0000) $display("FAIL midrst_state got %b want 0000", {cur_busy, cur_send, cur_grant}); else n_pass++;
    n_checks++; if ({cur_dc, cur_data} !== 9'h000) $display("FAIL midrst_data got %h want 000", {cur_dc, cur_data}); else n_pass++;
  endtask

  task automatic test_timeout();
    int c = 0;
    int n = 0;
    do_reset(1'b0);
    mdl_en = 1'b0;
    req0 = 1; data0 = 8'hC3;
    while (!cur_send && c < 10) begin step(); c++; end
    while (cur_send && n < 200) begin step(); n++; end
    req0 = 0;
`ifdef SPI_TIMEOUT_EN
    n_checks++; if (n != 64) $display("FAIL tmo_send_cycles got %0d want 64", n); else n_pass++;
    n_checks++; if (cur_tmo !== 1'b1) $display("FAIL tmo_flag got %b want 1", cur_tmo); else n_pass++;
    step(); step();
    n_checks++; if ({cur_busy, cur_tmo} !== 2'b01) $display("FAIL tmo_idle_sticky got %b want 01", {cur_busy, cur_tmo}); else n_pass++;
    n_checks++; if (acks_q.size() != 0) $display("FAIL tmo_no_ack got %0d want 0", acks_q.size()); else n_pass++;
    rst_rr = 1'b1; step(); rst_rr = 1'b0;
    n_checks++; if (cur_tmo !== 1'b0) $display("FAIL tmo_cleared got %b want 0", cur_tmo); else n_pass++;
`else
    n_checks++; if (n != 200) $display("FAIL notmo_send_held got %0d want 200", n); else n_pass++;
    n_checks++; if (cur_tmo !== 1'b0) $display("FAIL notmo_flag got %b want 0", cur_tmo); else n_pass++;
    rst_rr = 1'b1; step(); rst_rr = 1'b0;
`endif
  endtask

  initial begin
    rst_rr = 1'b1; rst_fx = 1'b1;
    req0 = 0; req1 = 0; dc0 = 0; dc1 = 0; lock0 = 0; lock1 = 0; data0 = 0; data1 = 0;
    test_reset();
    test_single_byte();
    test_round_robin();
    test_lock_burst();
    test_fixed_prio();
    test_stale_done();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
